// File: rtl/uop_pkg.sv
// Shared micro-op definitions for the dispatch/scheduling slice: uop tags,
// scheduler state encoding and the serializing-op classifier.
package uop_pkg;

  typedef enum logic [3:0] {
    UOP_INT_ALU        = 4'd0,
    UOP_INT_MUL        = 4'd1,
    UOP_LOAD           = 4'd2,
    UOP_STORE          = 4'd3,
    UOP_BRANCH         = 4'd4,
    UOP_LINK           = 4'd5,
    UOP_CAP_LOAN_BEGIN = 4'd6,
    UOP_CAP_LOAN_END   = 4'd7,
    UOP_CAP_JUMP       = 4'd8,
    UOP_CAP_RET        = 4'd9
  } uop_tag_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_SER = 2'd2
  } sched_state_e;

  // Capability jumps and returns must run with nothing else in flight.
  function automatic logic is_serializing_cap_uop(input uop_tag_t uop);
    return (uop == UOP_CAP_JUMP) || (uop == UOP_CAP_RET);
  endfunction

endpackage

// File: rtl/cap_credit_counter.sv
// Up/down counter of in-flight capability ops. Saturates at 0 (stray
// completions are ignored) and at CAP_CREDITS. Also reports whether the
// count will be zero after this cycle's update, for serialization release.
module cap_credit_counter #(
  parameter int CAP_CREDITS = 2,
  parameter int CRED_W      = $clog2(CAP_CREDITS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [CRED_W-1:0] count_o,
  output logic              have_credit_o,
  output logic              is_zero_o,
  output logic              next_is_zero_o
);

  localparam logic [CRED_W-1:0] MAX_COUNT = CRED_W'(CAP_CREDITS);

  logic [CRED_W-1:0] count_q;
  logic [CRED_W-1:0] count_d;
  logic              dec_eff;

  assign dec_eff = dec_i && (count_q != '0);

  // Net effect of an issue and a completion; a simultaneous pair cancels.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_eff) begin
      if (count_q < MAX_COUNT) count_d = count_q + CRED_W'(1);
    end else if (dec_eff && !inc_i) begin
      count_d = count_q - CRED_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o        = count_q;
  assign have_credit_o  = count_q < MAX_COUNT;
  assign is_zero_o      = count_q == '0;
  assign next_is_zero_o = count_d == '0;

endmodule

// File: rtl/cap_dispatch_sched.sv
// In-order dispatcher for 2-lane renamed bundles onto an integer port and a
// capability port, one lane per cycle, with credit metering of capability
// ops and full serialization around capability jumps/returns.
// Optional macro CAP_SCHED_PERF_EN builds the capability-stall cycle counter;
// without it stall_cycles_o reads zero.
module cap_dispatch_sched
  import uop_pkg::*;
#(
  parameter int MAX_UOPS    = 2,
  parameter int CAP_CREDITS = 2,
  parameter int CRED_W      = $clog2(CAP_CREDITS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rename_valid_i,
  input  uop_tag_t            rename_uop0_i,
  input  uop_tag_t            rename_uop1_i,
  input  logic [1:0]          rename_uop_count_i,
  input  logic [MAX_UOPS-1:0] rename_lane_is_cap_i,
  output logic                rename_ready_o,
  output logic                int_valid_o,
  output uop_tag_t            int_uop_o,
  input  logic                int_ready_i,
  output logic                cap_valid_o,
  output uop_tag_t            cap_uop_o,
  input  logic                cap_ready_i,
  input  logic                cap_done_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic [CRED_W-1:0]   cap_outstanding_o,
  output logic [15:0]         stall_cycles_o
);

  sched_state_e        state_q, state_d;
  uop_tag_t            uop0_q, uop1_q;
  logic [MAX_UOPS-1:0] cap_q;
  logic [1:0]          cnt_q;
  logic [1:0]          head_q;

  uop_tag_t head_uop;
  logic     head_cap, head_ser, cap_ok;
  logic     issue_int, issue_cap;
  logic     int_fire, cap_fire, fire, accept;
  logic     have_credit, is_zero, next_is_zero;

  assign head_uop  = head_q[0] ? uop1_q : uop0_q;
  assign head_cap  = cap_q[head_q[0]];
  assign head_ser  = is_serializing_cap_uop(head_uop);
  assign cap_ok    = head_ser ? is_zero : have_credit;
  assign issue_int = (state_q == ISSUE) && !head_cap;
  assign issue_cap = (state_q == ISSUE) && head_cap;

  assign int_fire = int_valid_o && int_ready_i;
  assign cap_fire = cap_valid_o && cap_ready_i;
  assign fire     = int_fire || cap_fire;
  assign accept   = rename_valid_i && rename_ready_o && (rename_uop_count_i != 2'd0);

  cap_credit_counter #(
    .CAP_CREDITS(CAP_CREDITS),
    .CRED_W     (CRED_W)
  ) u_credits (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .inc_i         (cap_fire),
    .dec_i         (cap_done_i),
    .count_o       (cap_outstanding_o),
    .have_credit_o (have_credit),
    .is_zero_o     (is_zero),
    .next_is_zero_o(next_is_zero)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; flush overrides everything and drops the bundle.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (accept) state_d = ISSUE;
        ISSUE: begin
          if (fire) begin
            if (head_cap && head_ser)         state_d = WAIT_SER;
            else if (head_q + 2'd1 >= cnt_q)  state_d = IDLE;
          end
        end
        WAIT_SER: if (next_is_zero) state_d = (head_q < cnt_q) ? ISSUE : IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Port handshakes; outputs are forced to their idle values while in reset.
  always_comb begin
    rename_ready_o = rst_i || ((state_q == IDLE) && !flush_i);
    int_valid_o    = issue_int && !flush_i && !rst_i;
    cap_valid_o    = issue_cap && cap_ok && !flush_i && !rst_i;
    int_uop_o      = (issue_int && !rst_i) ? head_uop : UOP_INT_ALU;
    cap_uop_o      = (issue_cap && !rst_i) ? head_uop : UOP_INT_ALU;
    busy_o         = !rst_i && (state_q != IDLE);
  end

  // Bundle buffer and head pointer; count 3 is clamped to the 2 real lanes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      uop0_q <= UOP_INT_ALU;
      uop1_q <= UOP_INT_ALU;
      cap_q  <= '0;
      cnt_q  <= 2'd0;
      head_q <= 2'd0;
    end else if (flush_i) begin
      cnt_q  <= 2'd0;
      head_q <= 2'd0;
    end else if (accept) begin
      uop0_q <= rename_uop0_i;
      uop1_q <= rename_uop1_i;
      cap_q  <= rename_lane_is_cap_i;
      cnt_q  <= (rename_uop_count_i == 2'd3) ? 2'd2 : rename_uop_count_i;
      head_q <= 2'd0;
    end else if (fire) begin
      head_q <= head_q + 2'd1;
    end
  end

`ifdef CAP_SCHED_PERF_EN
  logic [15:0] stall_q;
  logic        stall_hit;

  assign stall_hit = (state_q == WAIT_SER) || (issue_cap && !cap_ok);

  // Saturating count of cycles lost to capability credits or serialization.
  always_ff @(posedge clk_i) begin
    if (rst_i)                               stall_q <= 16'h0;
    else if (stall_hit && stall_q != 16'hFFFF) stall_q <= stall_q + 16'h1;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 16'h0;
`endif

endmodule

// File: tb/tb_cap_dispatch_sched.sv
// Directed bench for cap_dispatch_sched. A queue-based model of the pending
// lanes, the serialization wait and the credit count predicts every output
// each cycle; literal expectations at key points pin the model itself.
// Honours CAP_SCHED_PERF_EN for the expected stall count.
module tb_cap_dispatch_sched;
  import uop_pkg::*;

  localparam int CAP_CREDITS = 2;
  localparam int CRED_W      = $clog2(CAP_CREDITS + 1);

  logic              clk;
  logic              rst;
  logic              rename_valid;
  uop_tag_t          rename_uop0, rename_uop1;
  logic [1:0]        rename_count;
  logic [1:0]        rename_is_cap;
  logic              rename_ready;
  logic              int_valid;
  uop_tag_t          int_uop;
  logic              int_ready;
  logic              cap_valid;
  uop_tag_t          cap_uop;
  logic              cap_ready;
  logic              cap_done;
  logic              flush;
  logic              busy;
  logic [CRED_W-1:0] cap_outstanding;
  logic [15:0]       stall_cycles;

  cap_dispatch_sched #(
    .MAX_UOPS   (2),
    .CAP_CREDITS(CAP_CREDITS),
    .CRED_W     (CRED_W)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .rename_valid_i      (rename_valid),
    .rename_uop0_i       (rename_uop0),
    .rename_uop1_i       (rename_uop1),
    .rename_uop_count_i  (rename_count),
    .rename_lane_is_cap_i(rename_is_cap),
    .rename_ready_o      (rename_ready),
    .int_valid_o         (int_valid),
    .int_uop_o           (int_uop),
    .int_ready_i         (int_ready),
    .cap_valid_o         (cap_valid),
    .cap_uop_o           (cap_uop),
    .cap_ready_i         (cap_ready),
    .cap_done_i          (cap_done),
    .flush_i             (flush),
    .busy_o              (busy),
    .cap_outstanding_o   (cap_outstanding),
    .stall_cycles_o      (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit checking     = 1'b0;

  typedef struct {
    uop_tag_t tag;
    bit       cap;
  } lane_t;

  lane_t q[$];
  bit    m_ser;
  int    m_out;
  int    m_stall;

  logic     e_ready, e_iv, e_cv, e_busy, e_stallhit;
  uop_tag_t e_iu, e_cu;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs from the pending-lane queue and current inputs.
  task automatic model_eval();
    lane_t h;
    bit    ser, credit;
    e_ready = 1'b0; e_iv = 1'b0; e_cv = 1'b0; e_busy = 1'b0; e_stallhit = 1'b0;
    e_iu = UOP_INT_ALU; e_cu = UOP_INT_ALU;
    if (rst) begin
      e_ready = 1'b1;
    end else begin
      e_busy = (q.size() != 0) || m_ser;
      if (!e_busy) begin
        e_ready = !flush;
      end else if (m_ser) begin
        e_stallhit = 1'b1;
      end else begin
        h      = q[0];
        ser    = (h.tag == UOP_CAP_JUMP) || (h.tag == UOP_CAP_RET);
        credit = ser ? (m_out == 0) : (m_out < CAP_CREDITS);
        if (h.cap) begin
          e_cu       = h.tag;
          e_cv       = credit && !flush;
          e_stallhit = !credit;
        end else begin
          e_iu = h.tag;
          e_iv = !flush;
        end
      end
    end
  endtask

  // Mid-cycle: compare every output, then advance the model to the next edge.
  always begin
    bit fire_i, fire_c, ser;
    int nout;
    @(negedge clk);
    model_eval();
    if (checking) begin
      checkOutput("rename_ready", 32'(rename_ready), 32'(e_ready));
      checkOutput("int_valid", 32'(int_valid), 32'(e_iv));
      checkOutput("int_uop", 32'(int_uop), 32'(e_iu));
      checkOutput("cap_valid", 32'(cap_valid), 32'(e_cv));
      checkOutput("cap_uop", 32'(cap_uop), 32'(e_cu));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("outstanding", 32'(cap_outstanding), 32'(m_out));
`ifdef CAP_SCHED_PERF_EN
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`else
      checkOutput("stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    end
    if (rst) begin
      q.delete(); m_ser = 1'b0; m_out = 0; m_stall = 0;
    end else begin
      fire_i = e_iv && int_ready;
      fire_c = e_cv && cap_ready;
      if (e_stallhit && m_stall < 65535) m_stall++;
      nout = m_out + (fire_c ? 1 : 0) - ((cap_done && m_out > 0) ? 1 : 0);
      if (flush) begin
        q.delete();
        m_ser = 1'b0;
      end else if (e_ready && rename_valid && rename_count != 2'd0) begin
        q.push_back('{tag: rename_uop0, cap: rename_is_cap[0]});
        if (rename_count >= 2'd2) q.push_back('{tag: rename_uop1, cap: rename_is_cap[1]});
      end else if (fire_i || fire_c) begin
        ser = fire_c && ((q[0].tag == UOP_CAP_JUMP) || (q[0].tag == UOP_CAP_RET));
        void'(q.pop_front());
        if (ser) m_ser = 1'b1;
      end
      m_out = nout;
      if (m_ser && m_out == 0) m_ser = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Start a new cycle with the given inputs.
  task automatic applyStimulus(input logic v, input uop_tag_t u0, input uop_tag_t u1,
                               input logic [1:0] cnt, input logic [1:0] flags,
                               input logic ir, input logic cr, input logic done,
                               input logic fl);
    step();
    rename_valid  = v;
    rename_uop0   = u0;
    rename_uop1   = u1;
    rename_count  = cnt;
    rename_is_cap = flags;
    int_ready     = ir;
    cap_ready     = cr;
    cap_done      = done;
    flush         = fl;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, UOP_INT_ALU, UOP_INT_ALU, 2'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doneCycle();
    applyStimulus(1'b0, UOP_INT_ALU, UOP_INT_ALU, 2'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rename_valid = 1'b0; rename_uop0 = UOP_INT_ALU; rename_uop1 = UOP_INT_ALU;
    rename_count = 2'd0; rename_is_cap = 2'b00; int_ready = 1'b1; cap_ready = 1'b1;
    cap_done = 1'b0; flush = 1'b0;
    step();
    checking = 1'b1;
    mid();
    checkOutput("reset_ready", 32'(rename_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;

    // Mixed bundle: integer lane then capability lane.
    applyStimulus(1'b1, UOP_INT_ALU, UOP_LINK, 2'd2, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    mid(); checkOutput("t1_accept_ready", 32'(rename_ready), 32'd1);
    idleCycle();
    mid(); checkOutput("t1_int_valid", 32'(int_valid), 32'd1);
    checkOutput("t1_int_uop", 32'(int_uop), 32'(UOP_INT_ALU));
    idleCycle();
    mid(); checkOutput("t1_cap_valid", 32'(cap_valid), 32'd1);
    checkOutput("t1_cap_uop", 32'(cap_uop), 32'(UOP_LINK));
    idleCycle();
    mid(); checkOutput("t1_idle_ready", 32'(rename_ready), 32'd1);
    checkOutput("t1_outstanding", 32'(cap_outstanding), 32'd1);

    // Fill credits, then a capability op must wait for a completion.
    applyStimulus(1'b1, UOP_CAP_LOAN_BEGIN, UOP_INT_ALU, 2'd1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    mid(); checkOutput("t2_full", 32'(cap_outstanding), 32'd2);
    applyStimulus(1'b1, UOP_CAP_LOAN_BEGIN, UOP_INT_ALU, 2'd1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      mid(); checkOutput("t2_credit_block", 32'(cap_valid), 32'd0);
    end
    doneCycle();
    mid(); checkOutput("t2_done_cycle", 32'(cap_valid), 32'd0);
    idleCycle();
    mid(); checkOutput("t2_released", 32'(cap_valid), 32'd1);
    checkOutput("t2_out_after_done", 32'(cap_outstanding), 32'd1);
    idleCycle();
    mid(); checkOutput("t2_refilled", 32'(cap_outstanding), 32'd2);

    // Serializing return ahead of an integer op.
    doneCycle();
    applyStimulus(1'b1, UOP_CAP_RET, UOP_INT_ALU, 2'd2, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    mid(); checkOutput("t3_out_one", 32'(cap_outstanding), 32'd1);
    for (int i = 0; i < 2; i++) begin
      idleCycle();
      mid(); checkOutput("t3_ser_block", 32'(cap_valid), 32'd0);
    end
    doneCycle();
    mid(); checkOutput("t3_ser_block_done", 32'(cap_valid), 32'd0);
    idleCycle();
    mid(); checkOutput("t3_ret_valid", 32'(cap_valid), 32'd1);
    checkOutput("t3_ret_uop", 32'(cap_uop), 32'(UOP_CAP_RET));
    for (int i = 0; i < 2; i++) begin
      idleCycle();
      mid(); checkOutput("t3_wait_int", 32'(int_valid), 32'd0);
      checkOutput("t3_wait_busy", 32'(busy), 32'd1);
    end
    doneCycle();
    mid(); checkOutput("t3_wait_done", 32'(int_valid), 32'd0);
    idleCycle();
    mid(); checkOutput("t3_int_after", 32'(int_valid), 32'd1);
    checkOutput("t3_out_zero", 32'(cap_outstanding), 32'd0);
    idleCycle();

    // Integer backpressure holds valid and tag stable.
    applyStimulus(1'b1, UOP_INT_MUL, UOP_INT_ALU, 2'd2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, UOP_INT_ALU, UOP_INT_ALU, 2'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      mid(); checkOutput("t4_hold_valid", 32'(int_valid), 32'd1);
      checkOutput("t4_hold_uop", 32'(int_uop), 32'(UOP_INT_MUL));
      checkOutput("t4_hold_ready", 32'(rename_ready), 32'd0);
    end
    idleCycle();
    idleCycle();
    mid(); checkOutput("t4_lane1_uop", 32'(int_uop), 32'(UOP_INT_ALU));
    idleCycle();

    // Count 3 behaves as 2 lanes.
    applyStimulus(1'b1, UOP_INT_ALU, UOP_INT_MUL, 2'd3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    mid(); checkOutput("clamp_lane1", 32'(int_uop), 32'(UOP_INT_MUL));
    idleCycle();
    mid(); checkOutput("clamp_idle", 32'(busy), 32'd0);

    // Flush with lane 1 pending; outstanding survives the flush.
    applyStimulus(1'b1, UOP_CAP_LOAN_BEGIN, UOP_INT_ALU, 2'd1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(1'b1, UOP_INT_ALU, UOP_CAP_LOAN_END, 2'd2, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    mid(); checkOutput("t5_out_one", 32'(cap_outstanding), 32'd1);
    idleCycle();
    applyStimulus(1'b0, UOP_INT_ALU, UOP_INT_ALU, 2'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    mid(); checkOutput("t5_flush_cap_valid", 32'(cap_valid), 32'd0);
    idleCycle();
    mid(); checkOutput("t5_after_flush_busy", 32'(busy), 32'd0);
    checkOutput("t5_after_flush_out", 32'(cap_outstanding), 32'd1);
    doneCycle();
    idleCycle();
    mid(); checkOutput("t5_late_done", 32'(cap_outstanding), 32'd0);

    // Empty bundle, flush-blocked acceptance, fire+done in the same cycle.
    applyStimulus(1'b1, UOP_CAP_LOAN_BEGIN, UOP_CAP_LOAN_BEGIN, 2'd0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    mid(); checkOutput("t6_empty_busy", 32'(busy), 32'd0);
    checkOutput("t6_empty_cap", 32'(cap_valid), 32'd0);
    applyStimulus(1'b1, UOP_INT_ALU, UOP_INT_ALU, 2'd1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    mid(); checkOutput("t6_flush_ready", 32'(rename_ready), 32'd0);
    idleCycle();
    mid(); checkOutput("t6_flush_noaccept", 32'(busy), 32'd0);
    applyStimulus(1'b1, UOP_CAP_LOAN_BEGIN, UOP_INT_ALU, 2'd1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(1'b1, UOP_CAP_LOAN_BEGIN, UOP_INT_ALU, 2'd1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    mid(); checkOutput("t6_out_one", 32'(cap_outstanding), 32'd1);
    doneCycle();
    mid(); checkOutput("t6_fire_with_done", 32'(cap_valid), 32'd1);
    idleCycle();
    mid(); checkOutput("t6_net_zero", 32'(cap_outstanding), 32'd1);

    // Reset while waiting on a serializing jump.
    doneCycle();
    applyStimulus(1'b1, UOP_CAP_JUMP, UOP_INT_ALU, 2'd1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    mid(); checkOutput("t7_jump_uop", 32'(cap_uop), 32'(UOP_CAP_JUMP));
    idleCycle();
    mid(); checkOutput("t7_wait_busy", 32'(busy), 32'd1);
    checkOutput("t7_wait_out", 32'(cap_outstanding), 32'd1);
    idleCycle();
    rst = 1'b1;
    mid(); checkOutput("t7_rst_ready", 32'(rename_ready), 32'd1);
    checkOutput("t7_rst_busy", 32'(busy), 32'd0);
    idleCycle();
    rst = 1'b0;
    mid(); checkOutput("t7_rst_out", 32'(cap_outstanding), 32'd0);
    checkOutput("t7_rst_stall", 32'(stall_cycles), 32'd0);
    idleCycle();
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cap_dispatch_sched.md
Name: cap_dispatch_sched

Overview:
Sits between the rename stage and the two execution-side ports: an integer pipe and a capability unit. Accepts one renamed bundle of up to 2 micro-ops and issues its lanes strictly in order, one lane per cycle, each to the port its class selects. Meters capability ops with a credit counter against completions. Enforces full serialization around UOP_CAP_JUMP and UOP_CAP_RET.

Parameters:
MAX_UOPS, 2, lanes per bundle; fixed at 2.
CAP_CREDITS, 2, max capability ops outstanding; must be >= 1.
CRED_W, $clog2(CAP_CREDITS+1), width of the outstanding counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
rename_valid_i  in  1  bundle valid
rename_uop0_i  in  uop_tag_t  lane 0 tag
rename_uop1_i  in  uop_tag_t  lane 1 tag
rename_uop_count_i  in  2  lanes valid (0..2)
rename_lane_is_cap_i  in  MAX_UOPS  per-lane capability flag
rename_ready_o  out  1  bundle accepted when valid&&ready
int_valid_o  out  1  integer port request
int_uop_o  out  uop_tag_t  integer port tag
int_ready_i  in  1  integer port accept
cap_valid_o  out  1  capability port request
cap_uop_o  out  uop_tag_t  capability port tag
cap_ready_i  in  1  capability port accept
cap_done_i  in  1  one capability op completed this cycle
flush_i  in  1  discard buffered bundle
busy_o  out  1  state != IDLE
cap_outstanding_o  out  CRED_W  capability ops in flight
stall_cycles_o  out  16  saturating capability-stall cycle count

Behaviour:
- Reset (rst_i high at posedge): state=IDLE, buffer empty, head=0, outstanding=0, stall count=0.
  - Outputs during/after reset: rename_ready_o=1, all valids=0, busy_o=0, tags=UOP_INT_ALU.
- States: IDLE, ISSUE, WAIT_SER.
- IDLE:
  - rename_ready_o=1.
  - On rename_valid_i with count>=1: capture uops, lane flags and count, clamping count 3 to 2; set head=0; go ISSUE next cycle.
  - count==0: bundle accepted and dropped; stay in IDLE.
- ISSUE:
  - rename_ready_o=0. The head lane's tag drives the port its flag selects; the other port's valid=0.
  - Integer lane: int_valid_o=1; fire = int_ready_i.
  - Capability lane, non-serializing: cap_valid_o=1 iff outstanding < CAP_CREDITS.
  - Capability lane, serializing (UOP_CAP_JUMP, UOP_CAP_RET): cap_valid_o=1 iff outstanding==0.
  - On fire: head++. A capability fire increments outstanding.
  - A serializing fire goes to WAIT_SER. Otherwise, if head was the last lane go to IDLE, else stay in ISSUE.
  - Once asserted, valid and tag stay stable until fire or flush.
- WAIT_SER:
  - No valids, rename_ready_o=0.
  - When outstanding==0 (including the cycle its cap_done_i lands, next-state evaluated on the updated count): go ISSUE if lanes remain, else IDLE.
- Throughput: one lane per cycle. A bundle always has a 1-cycle bubble in IDLE before the next is accepted.
- Outstanding counter:
  - Same-cycle fire+done: net 0.
  - cap_done_i with outstanding==0: ignored, saturates at 0.
  - Never exceeds CAP_CREDITS.
- flush_i (highest priority):
  - Valids forced to 0 in the flush cycle; no fire occurs.
  - Buffer discarded; next state IDLE.
  - Outstanding counter unaffected, since in-flight ops still complete.
  - A flush while in IDLE also blocks acceptance that cycle: rename_ready_o=0.
- stall_cycles_o: +1 per cycle in WAIT_SER or in ISSUE with a capability head lane whose valid is suppressed by credits/serialization. Saturates at 16'hFFFF.

Optional Feature:
CAP_SCHED_PERF_EN:
- Defined: stall_cycles_o counts as above.
- Undefined: the counter register is not built and stall_cycles_o is tied to 16'h0.
- All other behaviour is identical in both builds.

Decomposition:
- In uop_pkg:
  - sched_state_e enum (IDLE, ISSUE, WAIT_SER).
  - function is_serializing_cap_uop(uop_tag_t), true for UOP_CAP_JUMP and UOP_CAP_RET.
- One sub-module, cap_credit_counter:
  - Parameterized up/down counter with saturation at 0 and CAP_CREDITS.
  - Outputs have_credit and is_zero.

Test Plan:
- Reset, then a bundle {UOP_INT_ALU, UOP_LINK}, count 2, flags 2'b10, both readies high -> int fires cycle 1, cap fires cycle 2, IDLE cycle 3; outstanding=1.
- CAP_CREDITS=2, outstanding=2, bundle {UOP_CAP_LOAN_BEGIN}, no done -> cap_valid_o held 0 and stall count rises by 1/cycle. One cap_done_i pulse -> valid next cycle, fires, outstanding=2 again.
- outstanding=1, bundle {UOP_CAP_RET, UOP_INT_ALU}, flags 2'b01 -> no issue until done brings outstanding to 0. CAP_RET fires, WAIT_SER until its done. INT_ALU then issues; no overlap observed.
- int_ready_i low for 5 cycles on lane 0 -> int_valid_o=1 and int_uop_o constant all 5 cycles; rename_ready_o=0 throughout.
- flush_i mid-ISSUE with lane 1 pending -> valids 0 that cycle, IDLE next cycle; a later cap_done_i still decrements outstanding.
- Count 0 bundle accepted in IDLE -> no port activity; simultaneous fire+done keeps outstanding at 1; rst_i asserted in WAIT_SER -> all reset values next cycle.
